// File: rtl/dmem_responder.sv
// Y86-64 data-memory responder: one 64-bit little-endian load/store in flight,
// single-cycle response a fixed LATENCY after accept, range errors flagged for SADR.
module dmem_responder #(
   parameter int unsigned MEM_BYTES = 2048,
   parameter int unsigned LATENCY   = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   output logic [63:0] resp_rdata,
   output logic        resp_error
);

   localparam int unsigned ADDR_W  = $clog2(MEM_BYTES);
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned DATA_W  = 64;
   localparam int unsigned NBYTES  = 8;
   localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - NBYTES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   logic [7:0]        mem [MEM_BYTES];

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              lat_write_q, lat_write_d;
   logic [63:0]       lat_addr_q, lat_addr_d;
   logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
   logic              armed_q;
   logic              req_ready_d;
   logic              resp_valid_d;
   logic              resp_error_d;
   logic [DATA_W-1:0] resp_rdata_d;

   logic              commit;
   logic              addr_err;
   logic              mem_we;
   logic [ADDR_W-1:0] base_idx;
   logic [DATA_W-1:0] rd_word;

   // Only the low index bits are meaningful; out-of-range accesses never touch the array.
   always_comb begin
      base_idx = ADDR_W'(lat_addr_q);
      addr_err = (lat_addr_q > MAX_ADDR);
      rd_word  = '0;
      for (int unsigned i = 0; i < NBYTES; i++) begin
         rd_word[8*i +: 8] = mem[base_idx + ADDR_W'(i)];
      end
   end

   assign mem_we = commit && lat_write_q && !addr_err;

   // Byte array is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int unsigned i = 0; i < NBYTES; i++) begin
            mem[base_idx + ADDR_W'(i)] <= lat_wdata_q[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         lat_write_q <= 1'b0;
         lat_addr_q  <= '0;
         lat_wdata_q <= '0;
         armed_q     <= 1'b0;
         req_ready   <= 1'b0;
         resp_valid  <= 1'b0;
         resp_error  <= 1'b0;
         resp_rdata  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         lat_write_q <= lat_write_d;
         lat_addr_q  <= lat_addr_d;
         lat_wdata_q <= lat_wdata_d;
         armed_q     <= 1'b1;
         req_ready   <= req_ready_d;
         resp_valid  <= resp_valid_d;
         resp_error  <= resp_error_d;
         resp_rdata  <= resp_rdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      lat_write_d  = lat_write_q;
      lat_addr_d   = lat_addr_q;
      lat_wdata_d  = lat_wdata_q;
      resp_valid_d = 1'b0;
      resp_error_d = resp_error;
      resp_rdata_d = resp_rdata;
      commit       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready) begin
               state_d     = S_WAIT;
               cnt_d       = CNT_W'(LATENCY - 1);
               lat_write_d = req_write;
               lat_addr_d  = req_addr;
               lat_wdata_d = req_wdata;
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               state_d      = S_RESP;
               commit       = 1'b1;
               resp_valid_d = 1'b1;
               resp_error_d = addr_err;
               resp_rdata_d = (!lat_write_q && !addr_err) ? rd_word : '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // armed_q holds ready low on the first edge after reset release.
      req_ready_d = armed_q && (state_d == S_IDLE);
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed timing/boundary steps plus a
// randomized phase scored against a byte-array reference model.
module tb_dmem_responder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic v0 = 1'b0, w0 = 1'b0, v1 = 1'b0, w1 = 1'b0;
   logic [63:0] a0 = '0, d0 = '0, a1 = '0, d1 = '0;
   logic rdy0, rv0, re0, rdy1, rv1, re1;
   logic [63:0] rd0, rd1;

   always #5 clk = ~clk;

   dmem_responder #(.MEM_BYTES(2048), .LATENCY(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(v0), .req_ready(rdy0), .req_write(w0), .req_addr(a0), .req_wdata(d0),
      .resp_valid(rv0), .resp_rdata(rd0), .resp_error(re0));

   dmem_responder #(.MEM_BYTES(2048), .LATENCY(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(v1), .req_ready(rdy1), .req_write(w1), .req_addr(a1), .req_wdata(d1),
      .resp_valid(rv1), .resp_rdata(rd1), .resp_error(re1));

   int n_assert = 0;
   int n_fail = 0;

   logic [7:0] mm [2][2048];

   typedef struct {
      logic        wr;
      logic [63:0] addr;
      logic [63:0] wd;
      int          due;
   } req_t;
   req_t q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int sel, input logic v, input logic w, input logic [63:0] a,
                        input logic [63:0] d);
      if (sel == 0) begin v0 = v; w0 = w; a0 = a; d0 = d; end
      else begin v1 = v; w1 = w; a1 = a; d1 = d; end
   endtask

   // Reference: sequential memory, legal iff last byte fits, little-endian bytes.
   task automatic model_commit(input int sel, input logic wr, input logic [63:0] addr,
                               input logic [63:0] wd, output logic err, output logic [63:0] rd);
      int base;
      err  = (addr + 64'd7 > 64'd2047) || (addr > 64'd2047);
      rd   = '0;
      base = int'(addr[10:0]);
      if (!err) begin
         for (int i = 0; i < 8; i++) begin
            if (wr) mm[sel][base + i] = wd[8*i +: 8];
            else    rd[8*i +: 8] = mm[sel][base + i];
         end
      end
   endtask

   function automatic logic [63:0] pick_addr();
      int r;
      r = int'($urandom_range(0, 15));
      if (r == 0)      return 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
      else if (r == 1) return 64'd2040 + 64'($urandom_range(0, 7));
      else             return 64'($urandom_range(0, 2040));
   endfunction

   // Full handshake with cycle-exact timing checks; called at posedge+1.
   task automatic do_access(input int sel, input logic wr, input logic [63:0] addr,
                            input logic [63:0] wd, input string tag);
      int lat;
      int budget;
      logic exp_err;
      logic [63:0] exp_rd;
      lat = (sel == 0) ? 2 : 1;
      drive(sel, 1'b1, wr, addr, wd);
      budget = 0;
      while (((sel == 0) ? rdy0 : rdy1) !== 1'b1 && budget < 50) begin
         @(posedge clk); #1;
         budget++;
      end
      chk({tag, "_ready_wait"}, 64'((sel == 0) ? rdy0 : rdy1), 64'(1));
      if (budget >= 50) begin
         drive(sel, 1'b0, 1'b0, '0, '0);
         return;
      end
      @(posedge clk); #1;
      drive(sel, 1'b0, ~wr, {$urandom, $urandom}, {$urandom, $urandom});
      model_commit(sel, wr, addr, wd, exp_err, exp_rd);
      for (int j = 0; j < lat; j++) begin
         chk({tag, "_early_valid"}, 64'((sel == 0) ? rv0 : rv1), 64'(0));
         chk({tag, "_busy_ready"}, 64'((sel == 0) ? rdy0 : rdy1), 64'(0));
         @(posedge clk); #1;
      end
      chk({tag, "_resp_valid"}, 64'((sel == 0) ? rv0 : rv1), 64'(1));
      chk({tag, "_resp_error"}, 64'((sel == 0) ? re0 : re1), 64'(exp_err));
      chk({tag, "_resp_rdata"}, (sel == 0) ? rd0 : rd1, exp_rd);
      chk({tag, "_resp_ready"}, 64'((sel == 0) ? rdy0 : rdy1), 64'(0));
      @(posedge clk); #1;
      chk({tag, "_after_valid"}, 64'((sel == 0) ? rv0 : rv1), 64'(0));
      chk({tag, "_after_ready"}, 64'((sel == 0) ? rdy0 : rdy1), 64'(1));
      chk({tag, "_hold_error"}, 64'((sel == 0) ? re0 : re1), 64'(exp_err));
      chk({tag, "_hold_rdata"}, (sel == 0) ? rd0 : rd1, exp_rd);
   endtask

   initial begin
      logic vv;
      logic exp_v;
      logic exp_err;
      logic [63:0] exp_rd;

      // reset state
      #1;
      chk("rst_ready", 64'(rdy0), 64'(0));
      chk("rst_valid", 64'(rv0), 64'(0));
      chk("rst_error", 64'(re0), 64'(0));
      chk("rst_rdata", rd0, 64'(0));
      #11 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rel_edge1_ready", 64'(rdy0), 64'(0));
      @(posedge clk); #1;
      chk("rel_edge2_ready", 64'(rdy0), 64'(1));

      // T1 / T2
      do_access(0, 1'b1, 64'h10, 64'h1122334455667788, "t1_wr");
      do_access(0, 1'b1, 64'h18, 64'h0, "t2_wr18");
      do_access(0, 1'b0, 64'h10, 64'h0, "t2_rd10");
      chk("t2_rd10_const", rd0, 64'h1122334455667788);
      do_access(0, 1'b0, 64'h11, 64'h0, "t2_rd11");
      chk("t2_rd11_const", rd0, 64'h0011223344556677);

      // T3 boundaries, no wrap-around
      do_access(0, 1'b1, 64'h0, 64'h0102030405060708, "t3_wr0");
      do_access(0, 1'b1, 64'd2040, 64'hAA, "t3_wr2040");
      chk("t3_err2040", 64'(re0), 64'(0));
      do_access(0, 1'b1, 64'd2041, 64'hBB, "t3_wr2041");
      chk("t3_err2041", 64'(re0), 64'(1));
      do_access(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hCC, "t3_wrwrap");
      chk("t3_errwrap", 64'(re0), 64'(1));
      do_access(0, 1'b0, 64'd2040, 64'h0, "t3_rd2040");
      chk("t3_rd2040_const", rd0, 64'hAA);
      do_access(0, 1'b0, 64'h0, 64'h0, "t3_rd0");
      do_access(0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, "t3_rdmax");

      // fill memory with random bytes so every later read is of known content
      for (int i = 0; i < 256; i++) begin
         do_access(0, 1'b1, 64'(8 * i), {$urandom, $urandom}, "fill");
      end

      // T4 + random traffic: valid held high for the first 100 cycles while busy
      for (int n = 0; n < 612; n++) begin
         vv = (n < 600) && ((n < 100) || ($urandom_range(0, 3) != 0));
         drive(0, vv, 1'($urandom_range(0, 1)), pick_addr(), {$urandom, $urandom});
         if (vv && rdy0) q.push_back('{wr: w0, addr: a0, wd: d0, due: n + 3});
         @(posedge clk); #1;
         exp_v = (q.size() > 0) && (q[0].due == n + 1);
         chk("rnd_valid", 64'(rv0), 64'(exp_v));
         if (exp_v) begin
            model_commit(0, q[0].wr, q[0].addr, q[0].wd, exp_err, exp_rd);
            chk("rnd_error", 64'(re0), 64'(exp_err));
            chk("rnd_rdata", rd0, exp_rd);
            void'(q.pop_front());
         end
      end
      chk("rnd_drained", 64'(q.size()), 64'(0));

      // T5: reset during WAIT of a store discards it
      do_access(0, 1'b1, 64'h20, 64'h0, "t5_zero");
      do_access(0, 1'b0, 64'h10, 64'h0, "t5_pre_rd");
      drive(0, 1'b1, 1'b1, 64'h20, 64'hCAFE_F00D_1234_5678);
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, '0, '0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_ready", 64'(rdy0), 64'(0));
      chk("t5_rst_valid", 64'(rv0), 64'(0));
      chk("t5_rst_error", 64'(re0), 64'(0));
      chk("t5_rst_rdata", rd0, 64'(0));
      @(posedge clk); #1;
      chk("t5_rst_novalid", 64'(rv0), 64'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("t5_rel1_ready", 64'(rdy0), 64'(0));
      chk("t5_rel1_valid", 64'(rv0), 64'(0));
      @(posedge clk); #1;
      chk("t5_rel2_ready", 64'(rdy0), 64'(1));
      do_access(0, 1'b0, 64'h20, 64'h0, "t5_rd20");
      chk("t5_rd20_const", rd0, 64'h0);

      // T6: LATENCY=1 instance, store then immediate load
      do_access(1, 1'b1, 64'h40, 64'hDEAD, "t6_wr");
      do_access(1, 1'b0, 64'h40, 64'h0, "t6_rd");
      chk("t6_rd_const", rd1, 64'hDEAD);
      do_access(1, 1'b0, 64'd2044, 64'h0, "t6_rd_err");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
